// File: rtl/mem_loader_pkg.sv
// Shared types and frame-format constants for the program loader.
package mem_loader_pkg;

    typedef enum logic [2:0] {
        S_ADDR,
        S_CNT,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int ADDR_BYTES = 4;
    localparam int CNT_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mem_loader_byte_packer.sv
// Shifts bytes into a little-endian 32-bit word; strobes when the 4th byte lands.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic [31:0] word_next,
    output logic [1:0]  cnt,
    output logic        word_done
);

    // New byte enters at the top, so after four shifts byte 0 sits in [7:0].
    assign word_next = {din, word[31:8]};
    assign word_done = en && (cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            cnt  <= '0;
        end else begin
            if (en)
                word <= word_next;
            if (clr)
                cnt <= '0;
            else if (en)
                cnt <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Framed byte-stream loader: writes words to memory, then releases the core on a good checksum.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst_n,
    output logic        done,
    output logic        err
);

    state_t      state, state_nx;
    logic        xfer;
    logic        pk_en, pk_clr, pk_done;
    logic [1:0]  pk_cnt;
    logic [31:0] pk_word, pk_next;
    logic        addr_last, cnt_last, data_last;
    logic [15:0] cnt_val;
    logic [15:0] n_words, wcnt;
    logic [31:0] waddr;
    logic [7:0]  sum;

    assign in_ready = !rst && (state != S_DONE) && (state != S_ERR);
    assign xfer     = in_valid && in_ready;

    // One packer serves address, count and data; it is re-aligned after the 2-byte count.
    assign pk_en     = xfer && (state == S_ADDR || state == S_CNT || state == S_DATA);
    assign addr_last = pk_en && (state == S_ADDR) && (pk_cnt == 2'(ADDR_BYTES - 1));
    assign cnt_last  = pk_en && (state == S_CNT) && (pk_cnt == 2'(CNT_BYTES - 1));
    assign data_last = pk_done && (state == S_DATA) && ((wcnt + 16'd1) == n_words);
    assign pk_clr    = cnt_last;
    assign cnt_val   = {in_data, pk_word[31:24]};

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pk_clr),
        .en        (pk_en),
        .din       (in_data),
        .word      (pk_word),
        .word_next (pk_next),
        .cnt       (pk_cnt),
        .word_done (pk_done)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_ADDR;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_ADDR: if (addr_last)
                        state_nx = (pk_next[1:0] != 2'b00) ? S_ERR : S_CNT;
            S_CNT:  if (cnt_last) begin
                        if (cnt_val > 16'(MAX_WORDS))
                            state_nx = S_ERR;
                        else if (cnt_val == 16'd0)
                            state_nx = S_CSUM;
                        else
                            state_nx = S_DATA;
                    end
            S_DATA: if (data_last)
                        state_nx = S_CSUM;
            S_CSUM: if (xfer)
                        state_nx = (in_data == sum) ? S_DONE : S_ERR;
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            n_words   <= '0;
            wcnt      <= '0;
            waddr     <= '0;
            sum       <= '0;
        end else begin
            mem_wen <= 1'b0;
            if (xfer && state != S_CSUM)
                sum <= sum + in_data;
            if (addr_last)
                waddr <= pk_next;
            if (cnt_last) begin
                n_words <= cnt_val;
                wcnt    <= '0;
            end
            if (pk_done && state == S_DATA) begin
                mem_wen   <= 1'b1;
                mem_addr  <= waddr;
                mem_wdata <= pk_next;
                waddr     <= waddr + 32'(WORD_BYTES);
                wcnt      <= wcnt + 16'd1;
            end
        end
    end

    assign done      = (state == S_DONE);
    assign err       = (state == S_ERR);
    assign cpu_rst_n = (state == S_DONE);

endmodule

// File: tb/tb_mem_loader.sv
// Randomized frame bench for mem_loader against a byte-index frame model.
module tb_mem_loader;

    localparam int MAXW = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_wen, cpu_rst_n, done, err;
    logic [31:0] mem_addr, mem_wdata;

    int total = 0;
    int bad   = 0;

    logic [7:0]  fr[$];
    logic [31:0] wds[MAXW];
    logic [31:0] wr_addr[int];
    logic [31:0] wr_data[int];
    int          term;
    bit          exp_done;

    always #5 clk = ~clk;

    mem_loader #(.MAX_WORDS(MAXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Frame bytes: base, count, data (only for legal counts), checksum (+delta).
    task automatic build(input logic [31:0] base, input int n, input int delta);
        logic [7:0] s;
        fr.delete();
        for (int i = 0; i < 4; i++) fr.push_back(base[8*i +: 8]);
        fr.push_back(n[7:0]);
        fr.push_back(n[15:8]);
        if (n <= MAXW)
            for (int k = 0; k < n; k++)
                for (int b = 0; b < 4; b++) fr.push_back(wds[k][8*b +: 8]);
        s = 8'd0;
        foreach (fr[i]) s = s + fr[i];
        fr.push_back(s + 8'(delta));
    endtask

    // Parse the frame from the format rules: which byte ends it, outcome, and which
    // byte transfers complete a word (keyed by byte index).
    task automatic model();
        logic [31:0] base;
        int          n;
        logic [7:0]  s;
        wr_addr.delete();
        wr_data.delete();
        base = {fr[3], fr[2], fr[1], fr[0]};
        n    = int'({fr[5], fr[4]});
        if (base[1:0] != 2'b00) begin
            term = 3; exp_done = 0; return;
        end
        if (n > MAXW) begin
            term = 5; exp_done = 0; return;
        end
        for (int k = 0; k < n; k++) begin
            wr_addr[6 + 4*k + 3] = base + 32'(4*k);
            wr_data[6 + 4*k + 3] = {fr[6+4*k+3], fr[6+4*k+2], fr[6+4*k+1], fr[6+4*k]};
        end
        term = 6 + 4*n;
        s = 8'd0;
        for (int i = 0; i < term; i++) s = s + fr[i];
        exp_done = (s == fr[term]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_wen", mem_wen, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_cpu", cpu_rst_n, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        #1;
        chk("rel_ready", in_ready, 1);
    endtask

    // Drive the frame (limit<0: whole frame up to its terminal byte) and check
    // every cycle's write strobe plus the outcome one cycle after the terminal byte.
    task automatic run(input bit gaps, input int limit);
        int idx = 0, prev = -1, cyc = 0, stall = 0;
        bit fin = 0, did5 = 0, v;
        model();
        while (!fin && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            v = (prev >= 0) && wr_addr.exists(prev);
            chk("wen", mem_wen, v);
            if (v) begin
                chk("waddr", mem_addr, wr_addr[prev]);
                chk("wdata", mem_wdata, wr_data[prev]);
            end
            if (limit < 0 && prev == term) begin
                chk("done", done, exp_done);
                chk("err", err, !exp_done);
                chk("cpu_rst_n", cpu_rst_n, exp_done);
                chk("ready_end", in_ready, 0);
                in_valid = 1'b0;
                fin = 1;
            end else if (limit >= 0 && idx >= limit) begin
                in_valid = 1'b0;
                fin = 1;
            end else begin
                if (stall > 0) begin
                    stall--; v = 0;
                end else if (gaps && idx == 8 && !did5) begin
                    stall = 4; did5 = 1; v = 0;
                end else if (gaps && $urandom_range(0, 3) == 0) begin
                    stall = $urandom_range(0, 4); v = 0;
                end else begin
                    v = 1;
                end
                if (v && idx == term)
                    chk("pre_flags", {30'd0, done, err}, 0);
                in_valid = v;
                in_data  = v ? fr[idx] : 8'($urandom);
                if (v && in_ready) begin
                    prev = idx;
                    idx++;
                end else begin
                    prev = -1;
                end
            end
        end
        if (!fin)
            chk("timeout", 1, 0);
        repeat (2) begin
            @(negedge clk);
            chk("idle_wen", mem_wen, 0);
        end
        if (limit < 0) chk("sticky", {done, err}, {exp_done, !exp_done});
    endtask

    initial begin
        logic [31:0] b;
        int n;
        do_reset();

        wds[0] = 32'h0000_0013;
        wds[1] = 32'h0010_0093;
        build(32'h0001_0000, 2, 0); run(0, -1);
        do_reset();
        build(32'h0001_0000, 2, 0); run(1, -1);
        do_reset();
        build(32'h0001_0000, 2, 1); run(0, -1);
        do_reset();
        build(32'h0001_0000, MAXW + 1, 0); run(0, -1);
        do_reset();
        build(32'h0001_0002, 2, 0); run(0, -1);
        do_reset();
        build(32'h0001_0000, 0, 0); run(1, -1);
        do_reset();
        build(32'h0001_0000, 2, 0); run(0, 8);
        do_reset();
        build(32'h0001_0000, 2, 0); run(0, -1);
        do_reset();

        wds[0] = 32'hDEAD_BEEF; wds[1] = 32'h0123_4567;
        wds[2] = 32'h89AB_CDEF; wds[3] = 32'hCAFE_F00D;
        build(32'hFFFF_FFF8, 4, 0); run(1, -1);
        do_reset();

        build(32'h0000_0100, MAXW, 0); run(0, -1);
        do_reset();

        for (int t = 0; t < 6; t++) begin
            b = $urandom & 32'hFFFF_FFFC;
            n = $urandom_range(0, 8);
            for (int k = 0; k < MAXW; k++) wds[k] = $urandom;
            build(b, n, ($urandom_range(0, 3) == 0) ? 1 : 0);
            run(1, -1);
            do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
